// File: rtl/sign_magnitude_unit_if.sv
// Valid/ready bundle for the sign/magnitude converter.
// The master drives input beats and consumes results. The slave is the converter itself.
interface sign_magnitude_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sign;
  logic             out_zero;
  logic             out_ovf;

  modport master (
    output in_valid, in_mode, in_data, in_sign, out_ready,
    input  in_ready, out_valid, out_data, out_sign, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_sign, out_ready,
    output in_ready, out_valid, out_data, out_sign, out_zero, out_ovf
  );
endinterface

// File: rtl/sign_magnitude_unit.sv
// Buffered sign/magnitude converter for the sequential signed multiplier.
// ABS mode (in_mode=0) turns a two's-complement operand into a magnitude and a sign.
// APPLY mode (in_mode=1) puts a sign back onto an unsigned magnitude.
// Each result is converted combinationally and stored in a DEPTH-entry FIFO.
// Optional macro SMU_SAT_EN: out-of-range APPLY results clamp and raise out_ovf.
// When the macro is undefined they wrap, and out_ovf stays 0.
module sign_magnitude_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  reset,
  sign_magnitude_unit_if.slave smu
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Each entry holds {data, sign, ovf}.
  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    rd_entry;
  logic             push, pop;
  logic [WIDTH-1:0] neg_data;
  logic [WIDTH-1:0] conv_data;
  logic             conv_sign;
  logic             conv_ovf;

`ifdef SMU_SAT_EN
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  logic apply_oor;
  // A positive result must be below 2^(W-1). A negative result may reach exactly -2^(W-1).
  assign apply_oor = (!smu.in_sign && smu.in_data[WIDTH-1]) ||
                     (smu.in_sign && (smu.in_data > MIN_MAG));
`endif

  assign neg_data = (~smu.in_data) + WIDTH'(1);

  // Convert the incoming beat so that the FIFO stores results that are ready to send.
  always_comb begin
    conv_data = smu.in_data;
    conv_sign = 1'b0;
    conv_ovf  = 1'b0;
    if (!smu.in_mode) begin
      // -2^(W-1) negates to 2^(W-1). This is still a valid unsigned magnitude.
      conv_sign = smu.in_data[WIDTH-1];
      conv_data = smu.in_data[WIDTH-1] ? neg_data : smu.in_data;
    end else begin
`ifdef SMU_SAT_EN
      if (apply_oor) begin
        conv_data = smu.in_sign ? MIN_MAG : MAX_POS;
        conv_sign = smu.in_sign;
        conv_ovf  = 1'b1;
      end else begin
        conv_data = smu.in_sign ? neg_data : smu.in_data;
        conv_sign = smu.in_sign && (smu.in_data != '0);
      end
`else
      // The result wraps. The sign is taken from the result itself, so a zero result is never negative.
      conv_data = smu.in_sign ? neg_data : smu.in_data;
      conv_sign = (conv_data != '0) && conv_data[WIDTH-1];
`endif
    end
  end

  // Handshakes. in_ready depends only on registered state (and reset), never on out_ready.
  assign smu.in_ready  = !reset && (state_reg != FULL);
  assign smu.out_valid = (state_reg != EMPTY);
  assign push          = smu.in_valid && smu.in_ready;
  assign pop           = smu.out_valid && smu.out_ready;

  // Occupancy FSM: choose the next count and the EMPTY/PARTIAL/FULL state.
  always_comb begin
    count_next = count_reg;
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (push) count_next = CW'(1);
      PARTIAL: begin
        if (push && !pop)      count_next = count_reg + CW'(1);
        else if (pop && !push) count_next = count_reg - CW'(1);
      end
      FULL:    if (pop) count_next = count_reg - CW'(1);
      default: count_next = '0;
    endcase
    if (count_next == '0)              state_next = EMPTY;
    else if (count_next == CW'(DEPTH)) state_next = FULL;
    else                               state_next = PARTIAL;
  end

  // Registers for state, count and pointers. Reset throws away every buffered beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= EMPTY;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // FIFO storage. The memory has no reset because the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {conv_data, conv_sign, conv_ovf};
  end

  // The head entry drives the outputs. All outputs are forced to 0 while nothing is buffered.
  assign rd_entry     = mem[rd_ptr_reg];
  assign smu.out_data = smu.out_valid ? rd_entry[EW-1:2] : '0;
  assign smu.out_sign = smu.out_valid && rd_entry[1];
  assign smu.out_ovf  = smu.out_valid && rd_entry[0];
  assign smu.out_zero = smu.out_valid && (rd_entry[EW-1:2] == '0);

endmodule
